alu_arbiter_ctrl: RTL

- Shares the combinational ALU datapath between two requesters, A and B, using valid/ready handshakes and round-robin arbitration.
- Registers the granted opcode and operands, drives the ALU selector and operand inputs, and waits the op-dependent latency: 1 cycle, or DIV_CYCLES for DIV.
- Captures the ALU result and returns it on a single response channel tagged with the requester ID.
- Sits between the decode/issue logic and the ALU in the ARM processor datapath.

---
 rtl/alu_arbiter_ctrl_if.sv | 54 +++++
 rtl/alu_arbiter_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_ctrl_if.sv
// Request, ALU and response signals of the two-requester ALU arbiter.
// slave  : the arbiter/controller side.
// master : the environment side (requesters, ALU and response consumer).
interface alu_arbiter_ctrl_if #(
    parameter int N = 32
);
    logic         A_VALID;
    logic         A_READY;
    logic [3:0]   A_OP;
    logic [N-1:0] A_OP1;
    logic [N-1:0] A_OP2;

    logic         B_VALID;
    logic         B_READY;
    logic [3:0]   B_OP;
    logic [N-1:0] B_OP1;
    logic [N-1:0] B_OP2;

    logic [3:0]   ALU_SELECTOR;
    logic [N-1:0] ALU_IN1;
    logic [N-1:0] ALU_IN2;
    logic [N-1:0] ALU_OUT;

    logic         RES_VALID;
    logic         RES_READY;
    logic         RES_ID;
    logic [N-1:0] RES_DATA;
    logic         RES_ERR;
    logic         RES_N;
    logic         RES_Z;
    logic         BUSY;

    modport slave (
        input  A_VALID, A_OP, A_OP1, A_OP2,
        output A_READY,
        input  B_VALID, B_OP, B_OP1, B_OP2,
        output B_READY,
        output ALU_SELECTOR, ALU_IN1, ALU_IN2,
        input  ALU_OUT,
        output RES_VALID, RES_ID, RES_DATA, RES_ERR, RES_N, RES_Z, BUSY,
        input  RES_READY
    );

    modport master (
        output A_VALID, A_OP, A_OP1, A_OP2,
        input  A_READY,
        output B_VALID, B_OP, B_OP1, B_OP2,
        input  B_READY,
        input  ALU_SELECTOR, ALU_IN1, ALU_IN2,
        output ALU_OUT,
        input  RES_VALID, RES_ID, RES_DATA, RES_ERR, RES_N, RES_Z, BUSY,
        output RES_READY
    );
endinterface

// File: rtl/alu_arbiter_ctrl.sv
// Round-robin arbiter sharing one combinational ALU between requesters A and B.
// A granted operation is registered onto the ALU inputs, held for the
// op-dependent latency (1 cycle, DIV_CYCLES for DIV), and the result is
// returned on one response channel tagged with the requester ID.
// Optional macro ALU_ARB_FLAGS_EN adds negative/zero flags to the response;
// without it RES_N/RES_Z are tied low.
module alu_arbiter_ctrl #(
    parameter int N          = 32,
    parameter int DIV_CYCLES = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    alu_arbiter_ctrl_if.slave  bus
);
    localparam logic [3:0] OP_DIV      = 4'b1010;
    localparam logic [3:0] OP_LAST     = 4'b1010;
    localparam logic [3:0] DIV_LOAD    = 4'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state_reg;
    logic         rr_last_reg;
    logic [3:0]   cnt_reg;
    logic [3:0]   sel_reg;
    logic [N-1:0] in1_reg;
    logic [N-1:0] in2_reg;
    logic         res_valid_reg;
    logic         res_id_reg;
    logic [N-1:0] res_data_reg;
    logic         res_err_reg;
    logic         res_n_reg;
    logic         res_z_reg;

    logic         grant_a;
    logic         grant_b;
    logic         a_ready;
    logic         b_ready;
    logic         handshake;
    logic         grant_id;
    logic [3:0]   req_op;
    logic [N-1:0] req_op1;
    logic [N-1:0] req_op2;
    logic         req_illegal;
    logic         capture;
    logic         err_load;

    // Grant selection: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_a     = bus.A_VALID && (!bus.B_VALID || rr_last_reg);
        grant_b     = bus.B_VALID && (!bus.A_VALID || !rr_last_reg);
        a_ready     = (state_reg == IDLE) && !RESET && grant_a;
        b_ready     = (state_reg == IDLE) && !RESET && grant_b;
        handshake   = a_ready || b_ready;
        grant_id    = b_ready;
        req_op      = b_ready ? bus.B_OP  : bus.A_OP;
        req_op1     = b_ready ? bus.B_OP1 : bus.A_OP1;
        req_op2     = b_ready ? bus.B_OP2 : bus.A_OP2;
        req_illegal = (req_op > OP_LAST);
        capture     = (state_reg == EXEC) && (cnt_reg == 4'd0);
        err_load    = handshake && req_illegal;
    end

    // Main FSM: accept, execute for the op latency, then hold the response until taken.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            rr_last_reg   <= 1'b1;
            cnt_reg       <= 4'd0;
            sel_reg       <= 4'd0;
            in1_reg       <= '0;
            in2_reg       <= '0;
            res_valid_reg <= 1'b0;
            res_id_reg    <= 1'b0;
            res_data_reg  <= '0;
            res_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        sel_reg     <= req_op;
                        in1_reg     <= req_op1;
                        in2_reg     <= req_op2;
                        rr_last_reg <= grant_id;
                        res_id_reg  <= grant_id;
                        if (req_illegal) begin
                            // Illegal opcode: answer immediately without using the ALU.
                            res_err_reg   <= 1'b1;
                            res_data_reg  <= '0;
                            res_valid_reg <= 1'b1;
                            state_reg     <= RESP;
                        end else begin
                            cnt_reg   <= (req_op == OP_DIV) ? DIV_LOAD : 4'd0;
                            state_reg <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (capture) begin
                        res_data_reg  <= bus.ALU_OUT;
                        res_err_reg   <= 1'b0;
                        res_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.RES_READY) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    // Result flags captured alongside RES_DATA; cleared on an error response.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            res_n_reg <= 1'b0;
            res_z_reg <= 1'b0;
        end else if (err_load) begin
            res_n_reg <= 1'b0;
            res_z_reg <= 1'b0;
        end else if (capture) begin
            res_n_reg <= bus.ALU_OUT[N-1];
            res_z_reg <= (bus.ALU_OUT == '0);
        end
    end
`else
    assign res_n_reg = 1'b0;
    assign res_z_reg = 1'b0;
`endif

    assign bus.A_READY      = a_ready;
    assign bus.B_READY      = b_ready;
    assign bus.ALU_SELECTOR = sel_reg;
    assign bus.ALU_IN1      = in1_reg;
    assign bus.ALU_IN2      = in2_reg;
    assign bus.RES_VALID    = res_valid_reg;
    assign bus.RES_ID       = res_id_reg;
    assign bus.RES_DATA     = res_data_reg;
    assign bus.RES_ERR      = res_err_reg;
    assign bus.RES_N        = res_n_reg;
    assign bus.RES_Z        = res_z_reg;
    assign bus.BUSY         = (state_reg != IDLE);
endmodule
